dmem_issue: RTL

DMEM_ISSUE -- requirements
Module: dmem_issue

---
 rtl/dmem_issue_pkg.sv | 63 ++++++
 rtl/dmem_issue_store_fmt.sv | 62 ++++++
 rtl/dmem_issue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_issue_pkg.sv
// Shared definitions for the data-memory issue stage: stall vector layout,
// EX->DC and DC->MEM bus layouts, op one-hot bit positions, exception bits.
// Latency: n/a (types and constants only). Backpressure: n/a.
package dmem_issue_pkg;

    // Global stall vector: one bit per pipeline stage.
    localparam int   STALL_WD  = 8;
    localparam int   STALL_DC  = 5;
    localparam int   STALL_MEM = 6;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    // Load one-hot {lb,lbu,lh,lhu,lw,lwl,lwr}, lb is the MSB.
    localparam int LD_WD  = 7;
    localparam int LD_LB  = 6;
    localparam int LD_LBU = 5;
    localparam int LD_LH  = 4;
    localparam int LD_LHU = 3;
    localparam int LD_LW  = 2;
    localparam int LD_LWL = 1;
    localparam int LD_LWR = 0;

    // Store one-hot {sb,sh,sw,swl,swr}, sb is the MSB.
    localparam int ST_WD  = 5;
    localparam int ST_SB  = 4;
    localparam int ST_SH  = 3;
    localparam int ST_SW  = 2;
    localparam int ST_SWL = 1;
    localparam int ST_SWR = 0;

    // Address-error exception bits in excepttype_arr.
    localparam int EXC_ADEL = 15;
    localparam int EXC_ADES = 14;

    // Request size encodings.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // First member sits in the MSBs of the flat bus.
    typedef struct packed {
        logic [31:0]       payload;
        logic [31:0]       bad_vaddr;
        logic [31:0]       excepttype_arr;
        logic [LD_WD-1:0]  load_op;
        logic [ST_WD-1:0]  store_op;
        logic [31:0]       rt_data;
        logic [31:0]       alu_result;
    } ex_to_dc_t;

    // The mem stage needs the load kind and vaddr to extract read data.
    typedef struct packed {
        logic [31:0]       payload;
        logic [31:0]       bad_vaddr;
        logic [31:0]       excepttype_arr;
        logic [LD_WD-1:0]  load_op;
        logic [31:0]       alu_result;
    } dc_to_mem_t;

    localparam int EX_TO_DC_WD  = $bits(ex_to_dc_t);
    localparam int DC_TO_MEM_WD = $bits(dc_to_mem_t);

endpackage

// File: rtl/dmem_issue_store_fmt.sv
// dc_store_fmt: combinational request formatter (size, word/byte address,
// write strobes, lane-aligned write data). Latency: 0 cycles. Backpressure: none.
// Ports: vaddr/rt_data/load_op/store_op in; size/addr/wstrb/wdata out.
module dc_store_fmt
    import dmem_issue_pkg::*;
(
    input  logic [31:0]      vaddr,
    input  logic [31:0]      rt_data,
    input  logic [LD_WD-1:0] load_op,
    input  logic [ST_WD-1:0] store_op,
    output logic [1:0]       size,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb
);

    always_comb begin
        size  = SZ_WORD;
        addr  = vaddr;
        wdata = 32'h0;
        wstrb = 4'b0000;

        if (load_op[LD_LB] || load_op[LD_LBU] || store_op[ST_SB]) begin
            size = SZ_BYTE;
        end else if (load_op[LD_LH] || load_op[LD_LHU] || store_op[ST_SH]) begin
            size = SZ_HALF;
        end

        // Partial-word ops always address the containing word.
        if (load_op[LD_LWL] || load_op[LD_LWR] || store_op[ST_SWL] || store_op[ST_SWR]) begin
            addr = {vaddr[31:2], 2'b00};
        end

        if (store_op[ST_SB]) begin
            wstrb = 4'b0001 << vaddr[1:0];
            wdata = {4{rt_data[7:0]}};
        end else if (store_op[ST_SH]) begin
            wstrb = vaddr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rt_data[15:0]}};
        end else if (store_op[ST_SW]) begin
            wstrb = 4'b1111;
            wdata = rt_data;
        end else if (store_op[ST_SWL]) begin
            // swl writes the high-order bytes of rt into the low lanes.
            case (vaddr[1:0])
                2'b00:   begin wstrb = 4'b0001; wdata = rt_data >> 24; end
                2'b01:   begin wstrb = 4'b0011; wdata = rt_data >> 16; end
                2'b10:   begin wstrb = 4'b0111; wdata = rt_data >> 8;  end
                default: begin wstrb = 4'b1111; wdata = rt_data;       end
            endcase
        end else if (store_op[ST_SWR]) begin
            // swr writes the low-order bytes of rt into the high lanes.
            case (vaddr[1:0])
                2'b00:   begin wstrb = 4'b1111; wdata = rt_data;       end
                2'b01:   begin wstrb = 4'b1110; wdata = rt_data << 8;  end
                2'b10:   begin wstrb = 4'b1100; wdata = rt_data << 16; end
                default: begin wstrb = 4'b1000; wdata = rt_data << 24; end
            endcase
        end
    end

endmodule

// File: rtl/dmem_issue.sv
// dmem_issue: data-cache issue stage; checks alignment, issues one SRAM request
// per load/store and registers the instruction into the DC->MEM bus.
// Latency: request combinational in IDLE; bus registered 1 cycle. Backpressure: stallreq_dc.
// Ports: clk/rst/flush/stall, ex_to_dc_bus in, dc_to_mem_bus out, data_sram_* handshake.
module dmem_issue
    import dmem_issue_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_DC_WD-1:0]  ex_to_dc_bus,
    output logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus,
    output logic                    data_sram_req,
    output logic                    data_sram_wr,
    output logic [1:0]              data_sram_size,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic [3:0]              data_sram_wstrb,
    input  logic                    data_sram_addr_ok,
    input  logic                    data_sram_data_ok,
    output logic                    stallreq_dc
);

    typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE, DRAIN} state_t;

    state_t      state, state_nxt;
    ex_to_dc_t   ex;
    dc_to_mem_t  stage_q, stage_d;
    logic        ld_misalign, st_misalign, is_store, issue_ok;
    logic        req_c, stallreq_c;
    logic [31:0] exc_new;
    logic [3:0]  fmt_wstrb;
    logic        unused_stall;

    assign ex           = ex_to_dc_bus;
    assign unused_stall = ^{stall[7], stall[4:0]};

    assign ld_misalign = ((ex.load_op[LD_LH] || ex.load_op[LD_LHU]) && ex.alu_result[0])
                      || (ex.load_op[LD_LW] && (ex.alu_result[1:0] != 2'b00));
    assign st_misalign = (ex.store_op[ST_SH] && ex.alu_result[0])
                      || (ex.store_op[ST_SW] && (ex.alu_result[1:0] != 2'b00));
    assign is_store    = |ex.store_op;

    always_comb begin
        exc_new = ex.excepttype_arr;
        if (ld_misalign) exc_new[EXC_ADEL] = 1'b1;
        if (st_misalign) exc_new[EXC_ADES] = 1'b1;
    end

    // Any pending exception (upstream or alignment) suppresses the access.
    assign issue_ok = ((|ex.load_op) || is_store) && (exc_new == 32'h0);

    always_comb begin
        stage_d                = '0;
        stage_d.payload        = ex.payload;
        stage_d.bad_vaddr      = (ld_misalign || st_misalign) ? ex.alu_result : ex.bad_vaddr;
        stage_d.excepttype_arr = exc_new;
        stage_d.load_op        = ex.load_op;
        stage_d.alu_result     = ex.alu_result;
    end

    dc_store_fmt u_fmt (
        .vaddr    (ex.alu_result),
        .rt_data  (ex.rt_data),
        .load_op  (ex.load_op),
        .store_op (ex.store_op),
        .size     (data_sram_size),
        .addr     (data_sram_addr),
        .wdata    (data_sram_wdata),
        .wstrb    (fmt_wstrb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_c      = 1'b0;
        stallreq_c = 1'b0;
        case (state)
            IDLE: begin
                if (issue_ok) begin
                    req_c = 1'b1;
                    if (data_sram_addr_ok) begin
                        state_nxt = flush ? DRAIN : WAIT_DATA;
                    end else begin
                        stallreq_c = 1'b1;
                        state_nxt  = flush ? IDLE : WAIT_ADDR;
                    end
                end
            end
            WAIT_ADDR: begin
                req_c      = 1'b1;
                stallreq_c = 1'b1;
                if (data_sram_addr_ok) state_nxt = flush ? DRAIN : WAIT_DATA;
                else if (flush)        state_nxt = IDLE;
            end
            WAIT_DATA: begin
                // data_ok cycle releases the stall so mem samples rdata on this edge.
                if (data_sram_data_ok) begin
                    state_nxt = (flush || stall[STALL_DC] == NO_STOP) ? IDLE : DONE;
                end else begin
                    stallreq_c = 1'b1;
                    if (flush) state_nxt = DRAIN;
                end
            end
            DONE: begin
                if (flush || stall[STALL_DC] == NO_STOP) state_nxt = IDLE;
            end
            DRAIN: begin
                // Swallow the response of a flushed access.
                stallreq_c = 1'b1;
                if (data_sram_data_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset forces the request side quiet even though the state is already IDLE.
    assign data_sram_req   = req_c && !rst;
    assign data_sram_wr    = data_sram_req && is_store;
    assign data_sram_wstrb = data_sram_req ? fmt_wstrb : 4'b0000;
    assign stallreq_dc     = stallreq_c && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (flush) begin
            stage_q <= '0;
        end else if (stall[STALL_DC] == NO_STOP && (state == IDLE || state == DONE)) begin
            stage_q <= stage_d;
        end else if (stall[STALL_DC] == STOP && stall[STALL_MEM] == NO_STOP) begin
            stage_q <= '0;
        end
    end

    assign dc_to_mem_bus = stage_q;

endmodule
